bridge_wr_fifo: RTL and testbench
=================================

# bridge_wr_fifo

Write-data buffer between the AXI write-data receiver and the APB master. It captures each beat pushed on `data_write`/`data` and presents the oldest beat first-word-fall-through on `data_in`; the APB master consumes it with `data_read`. Occupancy and status go to the bridge engine so it can throttle WREADY and sequence APB writes.

## Interface
- `DATA_WIDTH`, 32, beat width in bits.
- `DEPTH`, 8, number of entries; power of two, at least 2.
- `CNT_W`, $clog2(DEPTH)+1, occupancy width (derived; do not override).

- `clk`  in  1  single bridge clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `data_write`  in  1  push strobe from the AXI write-data side.
- `data`  in  DATA_WIDTH  push data.
- `data_read`  in  1  pop strobe from the APB master.
- `data_in`  out  DATA_WIDTH  head-of-queue data (FWFT).
- `flush`  in  1  synchronous clear from the bridge engine (abort or error).
- `full`  out  1  count == DEPTH.
- `empty`  out  1  count == 0.
- `count`  out  CNT_W  current occupancy.
- `overflow`  out  1  sticky: push attempted while full (see Configuration).
- `underflow`  out  1  sticky: pop attempted while empty (see Configuration).

## Operation
- Storage is a DEPTH x DATA_WIDTH register array. It has a write pointer and a read pointer, each $clog2(DEPTH) bits, plus a CNT_W occupancy counter.
- Pointers wrap modulo DEPTH by natural overflow. `full` and `empty` come from `count` only, never from pointer comparison.
- A push is accepted when `data_write` && (!full || accepted pop in the same cycle). It writes `data` to mem[wr_ptr] and increments wr_ptr.
- A pop is accepted when `data_read` && !empty. It increments rd_ptr.
- `data_in` = mem[rd_ptr], read combinationally. When empty, `data_in` is don't-care and the bench must not check it.
- Count update: +1 on push only, -1 on pop only, unchanged on both or neither.
- Simultaneous push and pop:
  - When full, both are accepted and count stays DEPTH.
  - When empty, only the push is accepted. The pop is rejected and counts as underflow.
- `flush` has priority over push and pop in the same cycle. It zeroes both pointers and the count, and discards the push. Memory contents are not cleared. Sticky flags are also cleared by flush.
- A rejected push leaves the stored data untouched. A rejected pop leaves rd_ptr untouched.

## Timing
- Reset values (async assert, outputs valid immediately): wr_ptr=0, rd_ptr=0, count=0, `empty`=1, `full`=0, `overflow`=0, `underflow`=0.
- The array is not reset, so `data_in` is undefined after reset.
- Reset deassertion takes effect on the next rising edge.
- Push-to-output latency is 1 cycle. A push on edge k makes `empty`=0 and `data_in`=pushed beat right after edge k, so a pop is allowed in cycle k+1.
- Pop latency is 0: `data_in` advances to the next entry right after the popping edge.
- `full`, `empty` and `count` are registered state (or decoded from `count`). They have no combinational path from `data_write`, `data_read` or `flush`.
- Reset mid-burst discards all contents. Upstream and downstream must re-handshake after reset.

## Configuration
- `BRIDGE_FIFO_ERR_EN` defined:
  - `overflow` sets on the edge where `data_write` && full && !(accepted pop).
  - `underflow` sets on the edge where `data_read` && empty.
  - Both flags hold until `flush` or reset.
- Not defined: `overflow` and `underflow` are tied to 0, no flag registers are built, and FIFO behaviour is otherwise identical.

## Test plan
- Reset, then push 0xA5A5_0001: after the edge, count=1, empty=0, `data_in`=0xA5A5_0001. Pop it: count=0, empty=1.
- DEPTH=8: push 0x10..0x17 for 8 cycles, giving full=1 and count=8. Pop 8 cycles: `data_in` sequence is 0x10..0x17, ending empty=1. Repeat 3 times to exercise pointer wrap with no data corruption.
- Full FIFO with push 0x99 and pop together: the head is popped, 0x99 is stored at the tail, count stays 8, and 0x99 emerges 8th.
- Empty FIFO with push 0x55 and pop together: count=1, `data_in`=0x55. With `BRIDGE_FIFO_ERR_EN`, `underflow`=1.
- Full FIFO with push 0xDEAD alone: count=8, contents unchanged. With `BRIDGE_FIFO_ERR_EN`, `overflow`=1 and it stays 1. A subsequent `flush` gives count=0, empty=1, overflow=0.
- `rst_n` pulsed low mid-cycle with 5 entries stored: count=0, empty=1, full=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/bridge_wr_fifo.sv
// -----------------------------------------------------------------------------
// bridge_wr_fifo
//   Write-data buffer between the AXI write-data receiver and the APB master.
//   Beats pushed on data_write/data are presented oldest-first on data_in in
//   first-word-fall-through form; the APB master consumes with data_read.
//
//   Optional feature macro: BRIDGE_FIFO_ERR_EN
//     defined     -> sticky overflow/underflow flag registers are built
//     not defined -> overflow/underflow are tied to 0
//
// Ports
//   clk        in   bridge clock, rising-edge state updates
//   rst_n      in   asynchronous active-low reset
//   data_write in   push strobe
//   data       in   push data (DATA_WIDTH)
//   data_read  in   pop strobe
//   data_in    out  head-of-queue data (FWFT), don't-care while empty
//   flush      in   synchronous clear, priority over push/pop
//   full       out  count == DEPTH
//   empty      out  count == 0
//   count      out  occupancy (CNT_W)
//   overflow   out  sticky: push attempted while full and no pop accepted
//   underflow  out  sticky: pop attempted while empty
//
// Handshake semantics: data_write and data_read are single-cycle strobes.
//   A push is taken on the rising edge when data_write is high and the FIFO is
//   not full, or a pop is taken on the same edge. A pop is taken on the rising
//   edge when data_read is high and the FIFO is not empty. Strobes that are not
//   taken have no effect on storage or pointers (only on the sticky flags).
// -----------------------------------------------------------------------------
module bridge_wr_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 8,
    parameter int CNT_W      = $clog2(DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  data_write,
    input  logic [DATA_WIDTH-1:0] data,
    input  logic                  data_read,
    output logic [DATA_WIDTH-1:0] data_in,
    input  logic                  flush,
    output logic                  full,
    output logic                  empty,
    output logic [CNT_W-1:0]      count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;

    logic push_acc;
    logic pop_acc;

    // Status is decoded from the registered count only.
    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign data_in = mem_q[rd_ptr_q];

    // A pop on a full FIFO frees the slot the simultaneous push lands in.
    assign pop_acc  = data_read && !empty;
    assign push_acc = data_write && (!full || pop_acc);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        mem_d    = mem_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_acc) begin
                mem_d[wr_ptr_q] = data;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (pop_acc) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            if (push_acc && !pop_acc) begin
                count_d = count_q + CNT_W'(1);
            end else if (pop_acc && !push_acc) begin
                count_d = count_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array is deliberately not reset; contents behind the pointers
    // are meaningless after reset or flush anyway.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

`ifdef BRIDGE_FIFO_ERR_EN
    logic overflow_q, overflow_d;
    logic underflow_q, underflow_d;

    always_comb begin
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (flush) begin
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end else begin
            if (data_write && full && !pop_acc) begin
                overflow_d = 1'b1;
            end
            if (data_read && empty) begin
                underflow_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign overflow  = overflow_q;
    assign underflow = underflow_q;
`else
    assign overflow  = 1'b0;
    assign underflow = 1'b0;
`endif

endmodule

// File: tb/tb_bridge_wr_fifo.sv
// -----------------------------------------------------------------------------
// tb_bridge_wr_fifo
//   Directed, table-driven bench for bridge_wr_fifo (DEPTH=8, DATA_WIDTH=32).
//   The table holds one record per clock: inputs driven before the edge and
//   the state expected right after it. Hand-written sequences cover pointer
//   wrap and mid-cycle asynchronous reset.
// -----------------------------------------------------------------------------
module tb_bridge_wr_fifo;

    localparam int DW    = 32;
    localparam int DEPTH = 8;
    localparam int CW    = $clog2(DEPTH) + 1;

`ifdef BRIDGE_FIFO_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic          clk = 1'b0;
    logic          rst_n;
    logic          data_write;
    logic [DW-1:0] data;
    logic          data_read;
    logic [DW-1:0] data_in;
    logic          flush;
    logic          full;
    logic          empty;
    logic [CW-1:0] count;
    logic          overflow;
    logic          underflow;

    always #5 clk = ~clk;

    bridge_wr_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .data_write (data_write),
        .data       (data),
        .data_read  (data_read),
        .data_in    (data_in),
        .flush      (flush),
        .full       (full),
        .empty      (empty),
        .count      (count),
        .overflow   (overflow),
        .underflow  (underflow)
    );

    // ---------------- vector table ----------------
    typedef struct {
        logic          wr;
        logic          rd;
        logic          fl;
        logic [DW-1:0] d;
        logic [CW-1:0] cnt;
        logic          chk;   // compare data_in only when non-empty
        logic [DW-1:0] dat;
        logic          ovf;   // flag value when the error flags are built
        logic          unf;
    } vec_t;

    vec_t vecs[$];

    int n_vec = 0;
    int n_err = 0;

    task automatic add(input logic wr, input logic rd, input logic fl,
                       input logic [DW-1:0] d, input int cnt, input logic chk,
                       input logic [DW-1:0] dat, input logic ovf, input logic unf);
        vec_t v;
        v.wr  = wr;
        v.rd  = rd;
        v.fl  = fl;
        v.d   = d;
        v.cnt = CW'(cnt);
        v.chk = chk;
        v.dat = dat;
        v.ovf = ovf;
        v.unf = unf;
        vecs.push_back(v);
    endtask

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input logic [DW-1:0] act,
                         input logic [DW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_state(input string tag, input int cnt, input logic chk,
                               input logic [DW-1:0] dat, input logic ovf,
                               input logic unf);
        check({tag, " count"}, DW'(count), DW'(cnt));
        check({tag, " empty"}, DW'(empty), DW'(cnt == 0));
        check({tag, " full"},  DW'(full),  DW'(cnt == DEPTH));
        check({tag, " overflow"},  DW'(overflow),  DW'(ERR_EN & ovf));
        check({tag, " underflow"}, DW'(underflow), DW'(ERR_EN & unf));
        if (chk) check({tag, " data_in"}, data_in, dat);
    endtask

    // ---------------- driver ----------------
    task automatic step(input logic wr, input logic rd, input logic fl,
                        input logic [DW-1:0] d);
        data_write = wr;
        data_read  = rd;
        flush      = fl;
        data       = d;
        @(posedge clk);
        #1;
        data_write = 1'b0;
        data_read  = 1'b0;
        flush      = 1'b0;
    endtask

    initial begin
        // Table: post-edge expectations derived by hand from FIFO behaviour.
        add(1, 0, 0, 32'hA5A5_0001, 1, 1, 32'hA5A5_0001, 0, 0);
        add(0, 1, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) add(1, 0, 0, 32'h10 + i, i + 1, 1, 32'h10, 0, 0);
        // full + push/pop: head 0x10 leaves, 0x99 joins at tail
        add(1, 1, 0, 32'h99, 8, 1, 32'h11, 0, 0);
        for (int j = 1; j < 8; j++)
            add(0, 1, 0, 0, 8 - j, 1, (j < 7) ? 32'h11 + j : 32'h99, 0, 0);
        add(0, 1, 0, 0, 0, 0, 0, 0, 0);
        // empty + push/pop: only the push is taken
        add(1, 1, 0, 32'h55, 1, 1, 32'h55, 0, 1);
        add(0, 0, 1, 0, 0, 0, 0, 0, 0);
        add(0, 1, 0, 0, 0, 0, 0, 0, 1);
        add(0, 0, 0, 0, 0, 0, 0, 0, 1);
        add(0, 0, 1, 0, 0, 0, 0, 0, 0);
        // fill, then push while full: rejected, contents intact
        for (int i = 0; i < 8; i++) add(1, 0, 0, 32'h20 + i, i + 1, 1, 32'h20, 0, 0);
        add(1, 0, 0, 32'hDEAD, 8, 1, 32'h20, 1, 0);
        add(0, 0, 0, 0, 8, 1, 32'h20, 1, 0);
        for (int j = 1; j < 8; j++) add(0, 1, 0, 0, 8 - j, 1, 32'h20 + j, 1, 0);
        add(0, 1, 0, 0, 0, 0, 0, 1, 0);
        add(0, 0, 1, 0, 0, 0, 0, 0, 0);
        // flush beats a simultaneous push
        add(1, 0, 1, 32'h77, 0, 0, 0, 0, 0);
        add(1, 0, 0, 32'h88, 1, 1, 32'h88, 0, 0);
        add(0, 0, 1, 0, 0, 0, 0, 0, 0);

        // reset
        data_write = 1'b0;
        data_read  = 1'b0;
        flush      = 1'b0;
        data       = '0;
        rst_n      = 1'b0;
        #2;
        check_state("reset", 0, 1'b0, '0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // table
        for (int k = 0; k < vecs.size(); k++) begin
            step(vecs[k].wr, vecs[k].rd, vecs[k].fl, vecs[k].d);
            check_state($sformatf("vec%0d", k), int'(vecs[k].cnt), vecs[k].chk,
                        vecs[k].dat, vecs[k].ovf, vecs[k].unf);
        end

        // pointer wrap: offset by one beat, then three fill/drain rounds
        step(1, 0, 0, 32'h1);
        step(0, 1, 0, 0);
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 8; i++) begin
                step(1, 0, 0, 32'h10 + i);
                check($sformatf("wrap%0d fill count", r), DW'(count), DW'(i + 1));
            end
            check($sformatf("wrap%0d full", r), DW'(full), 32'd1);
            for (int i = 0; i < 8; i++) begin
                check($sformatf("wrap%0d data_in%0d", r, i), data_in, 32'h10 + i);
                step(0, 1, 0, 0);
            end
            check($sformatf("wrap%0d empty", r), DW'(empty), 32'd1);
        end

        // async reset mid-cycle with 5 entries stored
        for (int i = 0; i < 5; i++) step(1, 0, 0, 32'h30 + i);
        check("pre-reset count", DW'(count), 32'd5);
        #2;
        rst_n = 1'b0;
        #1;
        check_state("async reset", 0, 1'b0, '0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(1, 0, 0, 32'h42);
        check_state("post-reset push", 1, 1'b1, 32'h42, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
